// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit for the MIPS decode/execute path.
// Extends a raw immediate per in_op, then carries {valid, ext, err} through STAGES registers.
module imm_ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IMM_W-1:0] in_imm,
  input  logic [2:0]       in_op,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_ext,
  output logic             out_err
);

  typedef enum logic [2:0] {
    OP_ZERO   = 3'b000,
    OP_UPPER  = 3'b001,
    OP_SIGN   = 3'b010,
    OP_BRANCH = 3'b011,
    OP_SHAMT  = 3'b100
  } op_e;

  // Narrow immediates have fewer than five bits to offer as a shift amount.
  localparam int SH_W = (IMM_W < 5) ? IMM_W : 5;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_d;
  logic             err_d;

  assign zext = OUT_W'(in_imm);
  assign sext = OUT_W'(signed'(in_imm));

  always_comb begin
    ext_d = '0;
    err_d = 1'b0;
    case (in_op)
      OP_ZERO:   ext_d = zext;
      OP_UPPER:  ext_d = zext << (OUT_W - IMM_W);
      OP_SIGN:   ext_d = sext;
      OP_BRANCH: ext_d = sext << 2;
      OP_SHAMT:  ext_d = OUT_W'(in_imm[SH_W-1:0]);
      default: begin
        ext_d = '0;
        err_d = 1'b1;
      end
    endcase
  end

  logic             valid_q [STAGES];
  logic [OUT_W-1:0] ext_q   [STAGES];
  logic             err_q   [STAGES];

  // Bubbles enter as all-zero so ext/err are guaranteed 0 whenever valid is 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        ext_q[k]   <= '0;
        err_q[k]   <= 1'b0;
      end
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        ext_q[k]   <= '0;
        err_q[k]   <= 1'b0;
      end
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      ext_q[0]   <= in_valid ? ext_d : '0;
      err_q[0]   <= in_valid & err_d;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        ext_q[k]   <= ext_q[k-1];
        err_q[k]   <= err_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_ext   = ext_q[STAGES-1];
  assign out_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three instances (1-stage, 3-stage, 16-bit 2-stage) share one input stream
// and are compared against an arithmetic reference model plus hand-derived constants.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_imm;
  logic [2:0]  in_op;
  logic        stall;
  logic        flush;

  logic        v1, r1, v3, r3, v16, r16;
  logic [31:0] e1, e3;
  logic [15:0] e16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IMM_W(16), .OUT_W(32), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_imm(in_imm), .in_op(in_op),
    .stall(stall), .flush(flush), .out_valid(v1), .out_ext(e1), .out_err(r1));

  imm_ext_pipe #(.IMM_W(16), .OUT_W(32), .STAGES(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_imm(in_imm), .in_op(in_op),
    .stall(stall), .flush(flush), .out_valid(v3), .out_ext(e3), .out_err(r3));

  imm_ext_pipe #(.IMM_W(16), .OUT_W(16), .STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_imm(in_imm), .in_op(in_op),
    .stall(stall), .flush(flush), .out_valid(v16), .out_ext(e16), .out_err(r16));

  typedef struct packed {
    logic        v;
    logic [63:0] e;
    logic        r;
  } ent_t;

  ent_t mdl [3][4];
  int   stg [3] = '{1, 3, 2};
  int   ow  [3] = '{32, 32, 16};

  // Reference extension computed with plain integer arithmetic on a 16-bit immediate.
  function automatic logic [63:0] refExt(input int out_w, input logic [15:0] imm,
                                         input logic [2:0] op, output logic err);
    longint      s;
    logic [63:0] mask;
    mask = (64'd1 << out_w) - 64'd1;
    err  = 1'b0;
    s    = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
    case (op)
      3'd0:    return 64'(imm) & mask;
      3'd1:    return 64'(longint'(imm) * (longint'(1) << (out_w - 16))) & mask;
      3'd2:    return 64'(s) & mask;
      3'd3:    return 64'(s * 4) & mask;
      3'd4:    return 64'(imm % 32) & mask;
      default: begin
        err = 1'b1;
        return 64'd0;
      end
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) mdl[i][k] = '0;
  endtask

  task automatic modelEdge();
    logic [63:0] ex;
    logic        er;
    for (int i = 0; i < 3; i++) begin
      if (flush) begin
        for (int k = 0; k < 4; k++) mdl[i][k] = '0;
      end else if (!stall) begin
        for (int k = stg[i] - 1; k > 0; k--) mdl[i][k] = mdl[i][k-1];
        ex = refExt(ow[i], in_imm, in_op, er);
        mdl[i][0] = in_valid ? ent_t'{1'b1, ex, er} : ent_t'('0);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "/d1.v"},  64'(v1),  64'(mdl[0][0].v));
    chk({tag, "/d1.e"},  64'(e1),  mdl[0][0].e);
    chk({tag, "/d1.r"},  64'(r1),  64'(mdl[0][0].r));
    chk({tag, "/d3.v"},  64'(v3),  64'(mdl[1][2].v));
    chk({tag, "/d3.e"},  64'(e3),  mdl[1][2].e);
    chk({tag, "/d3.r"},  64'(r3),  64'(mdl[1][2].r));
    chk({tag, "/d16.v"}, 64'(v16), 64'(mdl[2][1].v));
    chk({tag, "/d16.e"}, 64'(e16), mdl[2][1].e);
    chk({tag, "/d16.r"}, 64'(r16), 64'(mdl[2][1].r));
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [15:0] imm,
                               input logic [2:0] op, input logic st, input logic fl);
    in_valid = v;
    in_imm   = imm;
    in_op    = op;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "/v1"}, 64'(v1), 64'd0);
    chk({tag, "/e1"}, 64'(e1), 64'd0);
    chk({tag, "/v3"}, 64'(v3), 64'd0);
    chk({tag, "/e3"}, 64'(e3), 64'd0);
    chk({tag, "/r3"}, 64'(r3), 64'd0);
    chk({tag, "/v16"}, 64'(v16), 64'd0);
    chk({tag, "/e16"}, 64'(e16), 64'd0);
  endtask

  logic [31:0] dirExp [5] = '{32'h00008001, 32'h80010000, 32'hFFFF8001, 32'hFFFE0004, 32'h00000001};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_op = '0; stall = 1'b0; flush = 1'b0;
    modelReset();
    #2;
    checkAllZero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Five modes on 16'h8001 through the 1-stage instance
    for (int i = 0; i < 5; i++) begin
      applyStimulus("dir_ops", 1'b1, 16'h8001, 3'(i), 1'b0, 1'b0);
      chk("dir_ops/e1", 64'(e1), 64'(dirExp[i]));
      chk("dir_ops/v1", 64'(v1), 64'd1);
      chk("dir_ops/r1", 64'(r1), 64'd0);
    end

    applyStimulus("bad_op", 1'b1, 16'h1234, 3'b110, 1'b0, 1'b0);
    chk("bad_op/v1", 64'(v1), 64'd1);
    chk("bad_op/r1", 64'(r1), 64'd1);
    chk("bad_op/e1", 64'(e1), 64'd0);
    applyStimulus("sign_pos", 1'b1, 16'h7FFF, 3'b010, 1'b0, 1'b0);
    chk("sign_pos/e1", 64'(e1), 64'h7FFF);
    chk("sign_pos/r1", 64'(r1), 64'd0);

    // Stall two cycles after B enters the 3-stage pipe
    applyStimulus("clr", 1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    applyStimulus("stA", 1'b1, 16'h0001, 3'd0, 1'b0, 1'b0);
    applyStimulus("stB", 1'b1, 16'h0002, 3'd0, 1'b0, 1'b0);
    applyStimulus("stall1", 1'b1, 16'h0003, 3'd0, 1'b1, 1'b0);
    chk("stall1/v3", 64'(v3), 64'd0);
    applyStimulus("stall2", 1'b1, 16'h0003, 3'd0, 1'b1, 1'b0);
    chk("stall2/v3", 64'(v3), 64'd0);
    applyStimulus("stC", 1'b1, 16'h0003, 3'd0, 1'b0, 1'b0);
    chk("outA/v3", 64'(v3), 64'd1);
    chk("outA/e3", 64'(e3), 64'd1);
    applyStimulus("drain1", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("outB/e3", 64'(e3), 64'd2);
    applyStimulus("drain2", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("outC/e3", 64'(e3), 64'd3);
    applyStimulus("drain3", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("empty/v3", 64'(v3), 64'd0);

    // Flush together with stall on a full pipe
    applyStimulus("fill1", 1'b1, 16'h0011, 3'd0, 1'b0, 1'b0);
    applyStimulus("fill2", 1'b1, 16'h0022, 3'd0, 1'b0, 1'b0);
    applyStimulus("fill3", 1'b1, 16'h0033, 3'd0, 1'b0, 1'b0);
    chk("fill/e3", 64'(e3), 64'h11);
    applyStimulus("flush", 1'b1, 16'h5555, 3'd0, 1'b1, 1'b1);
    checkAllZero("flush");
    for (int i = 0; i < 3; i++) begin
      applyStimulus("postflush", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
      chk("postflush/v3", 64'(v3), 64'd0);
    end

    // Asynchronous reset between edges with the pipe full
    applyStimulus("rfill1", 1'b1, 16'hAAA1, 3'd2, 1'b0, 1'b0);
    applyStimulus("rfill2", 1'b1, 16'hAAA2, 3'd2, 1'b0, 1'b0);
    applyStimulus("rfill3", 1'b1, 16'hAAA3, 3'd2, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkAllZero("async_rst");
    modelReset();
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus("rel0", 1'b1, 16'h0042, 3'd0, 1'b0, 1'b0);
    chk("rel0/v3", 64'(v3), 64'd0);
    applyStimulus("rel1", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    applyStimulus("rel2", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("rel2/v3", 64'(v3), 64'd1);
    chk("rel2/e3", 64'(e3), 64'h42);

    // Equal widths: upper is identity, branch drops the top bits
    applyStimulus("w16_up", 1'b1, 16'hABCD, 3'd1, 1'b0, 1'b0);
    applyStimulus("w16_br", 1'b1, 16'hC001, 3'd3, 1'b0, 1'b0);
    chk("w16_up/e16", 64'(e16), 64'hABCD);
    applyStimulus("w16_drain", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("w16_br/e16", 64'(e16), 64'h0004);
    chk("w16_br/r16", 64'(r16), 64'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the decode/execute path of the MIPS datapath.
- Supports zero, upper-load, sign, branch-offset (sign, shift by 2) and shamt modes.
- Output is registered through STAGES pipeline stages, with pipeline stall and flush and a valid flag that marks real instructions versus bubbles.

Parameters:
- IMM_W, 16, immediate input width (2..OUT_W).
- OUT_W, 32, extended output width (IMM_W..64).
- STAGES, 1, number of register stages between input and output (1..4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  the current input carries a real instruction.
- in_imm  input  IMM_W  raw immediate field.
- in_op  input  3  extension mode select.
- stall  input  1  hold every stage; no shift.
- flush  input  1  kill every stage's contents.
- out_valid  output  1  the last stage holds a real instruction.
- out_ext  output  OUT_W  extended value from the last stage.
- out_err  output  1  the last stage's instruction used an undefined in_op.

Behaviour:
- Extension function (combinational, feeds stage 1):
  - op 000 zero: {zeros, in_imm}.
  - op 001 upper: in_imm << (OUT_W-IMM_W). If OUT_W==IMM_W the result is in_imm unchanged. For the defaults this gives {imm, 16'h0}.
  - op 010 sign: in_imm[IMM_W-1] replicated into the upper bits.
  - op 011 branch: sign-extended value << 2. Bits shifted past OUT_W are dropped, with no error.
  - op 100 shamt: zero-extended in_imm[4:0]. If IMM_W<5, all of in_imm is zero-extended.
  - op 101..111: ext=0, err=1.
- Each stage holds {valid, ext, err}. Stage k+1 takes stage k; stage 1 takes the extension function result.
- Bubble capture: when in_valid=0, stage 1 loads valid=0, ext=0, err=0. The extension result is ignored.
- Latency: an input sampled at edge N appears on the outputs after edge N+STAGES-1 (no stalls). The outputs are driven directly from the last stage and are never combinational from the inputs.
- Stall: when stall=1 and flush=0, every stage holds its value. The input sampled in that cycle is discarded; the upstream stage re-presents it.
- Flush: when flush=1, every stage loads valid=0, ext=0, err=0 at the edge.
  - Flush has priority over stall.
  - The input sampled in a flush cycle is discarded even if in_valid=1.
- Reset: asynchronous. While reset=1, all stages are forced to valid=0, ext=0, err=0, so out_valid=0, out_ext=0, out_err=0 immediately.
  - Reset mid-stream loses all in-flight entries.
  - The first capture after release is on the first rising edge with reset=0.
- Simultaneous events: reset dominates flush; flush dominates stall.
- out_ext and out_err are meaningful only when out_valid=1. They are guaranteed 0 when out_valid=0.
- No combinational path from any input to any output.

Test Plan:
- Default params, STAGES=1; in_imm=16'h8001 applied with ops 000, 001, 010, 011, 100 on consecutive cycles, in_valid=1.
  - Required outputs on successive cycles: 32'h00008001, 32'h80010000, 32'hFFFF8001, 32'hFFFE0004, 32'h00000001. err=0 and out_valid=1 throughout.
- in_op=3'b110, in_imm=16'h1234 -> one cycle later out_valid=1, out_err=1, out_ext=0. The next op 010 with 16'h7FFF -> 32'h00007FFF, err=0.
- STAGES=3: stream A=16'h0001, B=16'h0002, C=16'h0003 (op 000). Assert stall for 2 cycles after B enters.
  - A emerges 2 edges after its capture edge.
  - Outputs are frozen during the stall.
  - Order is preserved, with no duplicate or lost entries.
- STAGES=3: fill the pipe, then assert flush and stall together for 1 cycle.
  - out_valid=0 and out_ext=0 from the next edge.
  - The entry presented in the flush cycle never appears.
- Assert reset asynchronously between edges with the pipe full.
  - Outputs go to 0 and out_valid to 0 before the next edge.
  - After release, the first new input appears STAGES edges later.
- IMM_W=OUT_W=16, op 001 with 16'hABCD -> 16'hABCD. op 011 with 16'hC001 -> 16'h0004 (top bits dropped), err=0.
